// File: rtl/fp_accel_pkg.sv
// Shared definitions for the fingerprint accelerator stream blocks:
// width derivations, tkeep mask generation and packer FSM states.
package fp_accel_pkg;

    // Widest tkeep the mask helper can produce (4096-bit bus)
    localparam int unsigned KEEP_MAX = 512;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_e;

    function automatic int unsigned pair_width(input int unsigned id_width);
        return 2 * id_width;
    endfunction

    function automatic int unsigned lanes_per_word(input int unsigned bus_width,
                                                   input int unsigned id_width);
        return bus_width / (2 * id_width);
    endfunction

    // Low n*bytes_per_lane bits set; callers cast down to their own tkeep width.
    function automatic logic [KEEP_MAX-1:0] keep_from_lanes(input int unsigned n,
                                                            input int unsigned bytes_per_lane);
        logic [KEEP_MAX-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < n * bytes_per_lane) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register. 'free' tells the producer a new
// word may be loaded this cycle (empty, or the held word is being taken).
module axis_out_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [KEEP_W-1:0] ld_keep,
    input  logic              ld_last,
    output logic              free,
    output logic [DATA_W-1:0] tdata,
    output logic [KEEP_W-1:0] tkeep,
    output logic              tvalid,
    output logic              tlast,
    input  logic              tready
);

    assign free = !tvalid || tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= ld_data;
            tkeep  <= ld_keep;
            tlast  <= ld_last;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/id_pair_axis_packer.sv
// Packs one {ID_A, ID_B} pair per beat into LANES-wide AXI-Stream words,
// flushing partial words on tlast or after an idle timeout.
module id_pair_axis_packer
    import fp_accel_pkg::*;
#(
    parameter  int unsigned VEC_ID_WIDTH   = 8,
    parameter  int unsigned OUT_BUS_WIDTH  = 512,
    parameter  int unsigned TIMEOUT_CYCLES = 256,
    parameter  int unsigned PCNT_WIDTH     = 32,
    localparam int unsigned PAIR_WIDTH     = pair_width(VEC_ID_WIDTH),
    localparam int unsigned LANES          = lanes_per_word(OUT_BUS_WIDTH, VEC_ID_WIDTH)
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [PAIR_WIDTH-1:0]      S_AXIS_PAIR_tdata,
    input  logic                       S_AXIS_PAIR_tvalid,
    input  logic                       S_AXIS_PAIR_tlast,
    output logic                       S_AXIS_PAIR_tready,
    output logic [OUT_BUS_WIDTH-1:0]   M_AXIS_tdata,
    output logic [OUT_BUS_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                       M_AXIS_tvalid,
    output logic                       M_AXIS_tlast,
    input  logic                       M_AXIS_tready,
    output logic [PCNT_WIDTH-1:0]      o_PairCount,
    output logic                       o_Busy
);

    localparam int unsigned KEEP_W     = OUT_BUS_WIDTH / 8;
    localparam int unsigned PAIR_BYTES = PAIR_WIDTH / 8;
    localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W      = $clog2(LANES + 1);
    localparam int unsigned IDLE_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    pack_state_e              state, state_nx;
    logic [LANE_W-1:0]        lane, lane_nx;
    logic [OUT_BUS_WIDTH-1:0] acc, acc_nx, acc_ins;
    logic [CNT_W-1:0]         hold_cnt, hold_cnt_nx;
    logic                     hold_last, hold_last_nx;
    logic [IDLE_W-1:0]        idle, idle_nx;

    logic                     accept;
    logic                     complete;
    logic                     load;
    logic                     out_free;
    logic [OUT_BUS_WIDTH-1:0] word_data;
    logic [CNT_W-1:0]         word_cnt;
    logic                     word_last;
    logic [KEEP_W-1:0]        word_keep;

    // Readiness depends only on registered state; reset gates it low.
    assign S_AXIS_PAIR_tready = !ap_rst && (state == ST_FILL);
    assign accept             = S_AXIS_PAIR_tvalid && S_AXIS_PAIR_tready;

    always_comb begin
        acc_ins = acc;
        acc_ins[lane*PAIR_WIDTH +: PAIR_WIDTH] = S_AXIS_PAIR_tdata;
    end

    always_comb begin
        state_nx     = state;
        lane_nx      = lane;
        acc_nx       = acc;
        hold_cnt_nx  = hold_cnt;
        hold_last_nx = hold_last;
        idle_nx      = '0;
        complete     = 1'b0;
        load         = 1'b0;
        word_data    = acc;
        word_cnt     = hold_cnt;
        word_last    = hold_last;

        case (state)
            ST_FILL: begin
                if (accept) begin
                    acc_nx  = acc_ins;
                    lane_nx = lane + 1'b1;
                    if (S_AXIS_PAIR_tlast || (lane == LANE_LAST)) begin
                        complete  = 1'b1;
                        word_data = acc_ins;
                        word_cnt  = CNT_W'(lane) + CNT_W'(1);
                        word_last = S_AXIS_PAIR_tlast;
                    end
                end else if (lane != '0) begin
                    // An accepted beat above always wins over the timeout.
                    if (TO_EN && (idle == IDLE_LAST)) begin
                        complete  = 1'b1;
                        word_data = acc;
                        word_cnt  = CNT_W'(lane);
                        word_last = 1'b0;
                    end else if (TO_EN) begin
                        idle_nx = idle + 1'b1;
                    end
                end

                if (complete) begin
                    if (out_free) begin
                        load    = 1'b1;
                        acc_nx  = '0;
                        lane_nx = '0;
                    end else begin
                        acc_nx       = word_data;
                        hold_cnt_nx  = word_cnt;
                        hold_last_nx = word_last;
                        state_nx     = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (out_free) begin
                    load     = 1'b1;
                    acc_nx   = '0;
                    lane_nx  = '0;
                    state_nx = ST_FILL;
                end
            end

            default: state_nx = ST_FILL;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= ST_FILL;
            lane      <= '0;
            acc       <= '0;
            hold_cnt  <= '0;
            hold_last <= 1'b0;
            idle      <= '0;
        end else begin
            state     <= state_nx;
            lane      <= lane_nx;
            acc       <= acc_nx;
            hold_cnt  <= hold_cnt_nx;
            hold_last <= hold_last_nx;
            idle      <= idle_nx;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            o_PairCount <= '0;
        end else if (accept) begin
            o_PairCount <= o_PairCount + PCNT_WIDTH'(1);
        end
    end

    assign word_keep = KEEP_W'(keep_from_lanes(32'(word_cnt), PAIR_BYTES));

    axis_out_reg #(
        .DATA_W (OUT_BUS_WIDTH),
        .KEEP_W (KEEP_W)
    ) u_out (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .load    (load),
        .ld_data (word_data),
        .ld_keep (word_keep),
        .ld_last (word_last),
        .free    (out_free),
        .tdata   (M_AXIS_tdata),
        .tkeep   (M_AXIS_tkeep),
        .tvalid  (M_AXIS_tvalid),
        .tlast   (M_AXIS_tlast),
        .tready  (M_AXIS_tready)
    );

    assign o_Busy = (lane != '0) || (state == ST_HOLD) || M_AXIS_tvalid;

endmodule
